// File: rtl/buffer_pkg.sv
// Shared state encodings for the frame double-buffer write controller.
package buffer_pkg;

    typedef enum logic [1:0] {
        StFill     = 2'd0,
        StWaitSwap = 2'd1,
        StSwap     = 2'd2
    } buf_state_e;

endpackage

// File: rtl/buffer_swap_controller.sv
// Fills the back bank of a double buffer with one frame of producer words, then
// requests a bank swap on the next reader vblank and counts frames and late vblanks.
module buffer_swap_controller
    import buffer_pkg::*;
#(
    parameter int unsigned RAM_WIDTH     = 36,
    parameter int unsigned RAM_ADDR_BITS = 11,
    parameter int unsigned FRAME_WORDS   = 2048
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [RAM_WIDTH-1:0]     in_data,
    input  logic                     vblank_pulse,
    output logic                     buffer_switch_event,
    output logic                     write_enable,
    output logic [RAM_ADDR_BITS-1:0] write_addr,
    output logic [RAM_WIDTH-1:0]     write_data,
    output logic [15:0]              frame_count,
    output logic [7:0]               late_count,
    output logic [1:0]               state_out
);

    localparam logic [RAM_ADDR_BITS-1:0] LastAddr = RAM_ADDR_BITS'(FRAME_WORDS - 1);

    buf_state_e               r_state;
    logic [RAM_ADDR_BITS-1:0] r_wr_ptr;
    logic                     r_write_enable;
    logic [RAM_ADDR_BITS-1:0] r_write_addr;
    logic [RAM_WIDTH-1:0]     r_write_data;
    logic                     r_switch;
    logic [15:0]              r_frame_count;
    logic [7:0]               r_late_count;
    logic                     w_accept;

    assign in_ready            = (r_state == StFill);
    assign w_accept            = in_valid && in_ready;
    assign buffer_switch_event = r_switch;
    assign write_enable        = r_write_enable;
    assign write_addr          = r_write_addr;
    assign write_data          = r_write_data;
    assign frame_count         = r_frame_count;
    assign late_count          = r_late_count;
    assign state_out           = r_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= StFill;
            r_wr_ptr       <= '0;
            r_write_enable <= 1'b0;
            r_write_addr   <= '0;
            r_write_data   <= '0;
            r_switch       <= 1'b0;
            r_frame_count  <= '0;
            r_late_count   <= '0;
        end else begin
            r_write_enable <= w_accept;
            r_switch       <= 1'b0;
            if (w_accept) begin
                r_write_addr <= r_wr_ptr;
                r_write_data <= in_data;
            end

            case (r_state)
                StFill: begin
                    // A vblank that arrives while still filling is late, even on the final word.
                    if (vblank_pulse && (r_late_count != 8'hFF)) begin
                        r_late_count <= r_late_count + 8'd1;
                    end
                    if (w_accept) begin
                        if (r_wr_ptr == LastAddr) begin
                            r_wr_ptr <= '0;
                            r_state  <= StWaitSwap;
                        end else begin
                            r_wr_ptr <= r_wr_ptr + 1'b1;
                        end
                    end
                end
                StWaitSwap: begin
                    if (vblank_pulse) begin
                        r_state  <= StSwap;
                        r_switch <= 1'b1;
                    end
                end
                StSwap: begin
                    r_frame_count <= r_frame_count + 16'd1;
                    r_state       <= StFill;
                end
                default: begin
                    r_state <= StFill;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_buffer_swap_controller.sv
// Directed bench for buffer_swap_controller with a 4-word frame.
module tb_buffer_swap_controller;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [35:0] in_data;
    logic        vblank_pulse;
    logic        buffer_switch_event;
    logic        write_enable;
    logic [10:0] write_addr;
    logic [35:0] write_data;
    logic [15:0] frame_count;
    logic [7:0]  late_count;
    logic [1:0]  state_out;

    int errors;
    int checks;

    buffer_swap_controller #(
        .RAM_WIDTH    (36),
        .RAM_ADDR_BITS(11),
        .FRAME_WORDS  (4)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .in_data            (in_data),
        .vblank_pulse       (vblank_pulse),
        .buffer_switch_event(buffer_switch_event),
        .write_enable       (write_enable),
        .write_addr         (write_addr),
        .write_data         (write_data),
        .frame_count        (frame_count),
        .late_count         (late_count),
        .state_out          (state_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        vblank_pulse = 1'b0;
        in_data = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (state_out !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state_out); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
        checks++; if (write_enable !== 1'b0) begin errors++; $display("FAIL reset_we: got %0b want 0", write_enable); end
        checks++; if (write_addr !== 11'd0) begin errors++; $display("FAIL reset_addr: got %0d want 0", write_addr); end
        checks++; if (write_data !== 36'd0) begin errors++; $display("FAIL reset_data: got %0h want 0", write_data); end
        checks++; if (buffer_switch_event !== 1'b0) begin errors++; $display("FAIL reset_switch: got %0b want 0", buffer_switch_event); end
        checks++; if (frame_count !== 16'd0) begin errors++; $display("FAIL reset_frames: got %0d want 0", frame_count); end
        checks++; if (late_count !== 8'd0) begin errors++; $display("FAIL reset_late: got %0d want 0", late_count); end
    endtask

    task automatic test_fill();
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 36'h100 + 36'(i);
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_%0d: got %0b want 1", i, in_ready); end
            tick();
            checks++; if (write_enable !== 1'b1) begin errors++; $display("FAIL fill_we_%0d: got %0b want 1", i, write_enable); end
            checks++; if (write_addr !== 11'(i)) begin errors++; $display("FAIL fill_addr_%0d: got %0d want %0d", i, write_addr, i); end
            checks++; if (write_data !== 36'h100 + 36'(i)) begin errors++; $display("FAIL fill_data_%0d: got %0h want %0h", i, write_data, 36'h100 + 36'(i)); end
        end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_done_ready: got %0b want 0", in_ready); end
        checks++; if (state_out !== 2'd1) begin errors++; $display("FAIL fill_done_state: got %0d want 1", state_out); end
        // Valid held in WAIT_SWAP must not produce writes.
        tick();
        tick();
        checks++; if (write_enable !== 1'b0) begin errors++; $display("FAIL wait_no_write: got %0b want 0", write_enable); end
        checks++; if (state_out !== 2'd1) begin errors++; $display("FAIL wait_hold: got %0d want 1", state_out); end
        in_valid = 1'b0;
    endtask

    task automatic test_swap();
        vblank_pulse = 1'b1;
        tick();
        checks++; if (buffer_switch_event !== 1'b1) begin errors++; $display("FAIL swap_pulse: got %0b want 1", buffer_switch_event); end
        checks++; if (state_out !== 2'd2) begin errors++; $display("FAIL swap_state: got %0d want 2", state_out); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL swap_ready: got %0b want 0", in_ready); end
        // vblank still high during the SWAP cycle is ignored.
        tick();
        vblank_pulse = 1'b0;
        checks++; if (buffer_switch_event !== 1'b0) begin errors++; $display("FAIL swap_one_cycle: got %0b want 0", buffer_switch_event); end
        checks++; if (frame_count !== 16'd1) begin errors++; $display("FAIL swap_frames: got %0d want 1", frame_count); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL swap_ready_after: got %0b want 1", in_ready); end
        checks++; if (late_count !== 8'd0) begin errors++; $display("FAIL swap_vblank_ignored: got %0d want 0", late_count); end
    endtask

    task automatic test_late();
        for (int i = 0; i < 3; i++) begin
            vblank_pulse = 1'b1;
            tick();
            vblank_pulse = 1'b0;
            tick();
        end
        checks++; if (late_count !== 8'd3) begin errors++; $display("FAIL late_three: got %0d want 3", late_count); end
        for (int i = 0; i < 300; i++) begin
            vblank_pulse = 1'b1;
            tick();
            vblank_pulse = 1'b0;
            tick();
        end
        checks++; if (late_count !== 8'd255) begin errors++; $display("FAIL late_saturate: got %0d want 255", late_count); end
        checks++; if (state_out !== 2'd0) begin errors++; $display("FAIL late_state: got %0d want 0", state_out); end
    endtask

    task automatic test_toggle();
        int writes;
        writes = 0;
        for (int c = 0; c < 8; c++) begin
            in_valid = (c % 2 == 0);
            in_data = 36'h200 + 36'(c);
            tick();
            checks++; if (write_enable !== in_valid) begin errors++; $display("FAIL toggle_we_%0d: got %0b want %0b", c, write_enable, in_valid); end
            if (write_enable) begin
                writes++;
                checks++; if (write_addr !== 11'(c / 2)) begin errors++; $display("FAIL toggle_addr_%0d: got %0d want %0d", c, write_addr, c / 2); end
            end
        end
        checks++; if (writes != 4) begin errors++; $display("FAIL toggle_count: got %0d want 4", writes); end
        checks++; if (state_out !== 2'd1) begin errors++; $display("FAIL toggle_state: got %0d want 1", state_out); end
        in_valid = 1'b1;
        vblank_pulse = 1'b1;
        tick();
        vblank_pulse = 1'b0;
        checks++; if (write_enable !== 1'b0) begin errors++; $display("FAIL toggle_swap_no_write: got %0b want 0", write_enable); end
        tick();
        checks++; if (write_enable !== 1'b0) begin errors++; $display("FAIL toggle_post_swap_no_write: got %0b want 0", write_enable); end
        checks++; if (frame_count !== 16'd2) begin errors++; $display("FAIL toggle_frames: got %0d want 2", frame_count); end
        tick();
        checks++; if (write_enable !== 1'b1 || write_addr !== 11'd0) begin errors++; $display("FAIL toggle_next_frame: got we=%0b addr=%0d want we=1 addr=0", write_enable, write_addr); end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        in_valid = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        checks++; if (buffer_switch_event !== 1'b0 || frame_count !== 16'd0 || late_count !== 8'd0) begin errors++; $display("FAIL midreset_counters: got sw=%0b fc=%0d lc=%0d want 0 0 0", buffer_switch_event, frame_count, late_count); end
        checks++; if (write_enable !== 1'b0 || state_out !== 2'd0) begin errors++; $display("FAIL midreset_state: got we=%0b st=%0d want 0 0", write_enable, state_out); end
        in_valid = 1'b1;
        tick();
        checks++; if (write_enable !== 1'b1 || write_addr !== 11'd0) begin errors++; $display("FAIL midreset_restart: got we=%0b addr=%0d want 1 0", write_enable, write_addr); end
        tick();
        tick();
        tick();
        in_valid = 1'b0;
        checks++; if (state_out !== 2'd1 || write_addr !== 11'd3) begin errors++; $display("FAIL midreset_full: got st=%0d addr=%0d want 1 3", state_out, write_addr); end
        // Reset while waiting for vblank: the pending swap is dropped.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vblank_pulse = 1'b1;
        tick();
        vblank_pulse = 1'b0;
        checks++; if (buffer_switch_event !== 1'b0 || state_out !== 2'd0) begin errors++; $display("FAIL waitreset_no_swap: got sw=%0b st=%0d want 0 0", buffer_switch_event, state_out); end
        checks++; if (late_count !== 8'd1) begin errors++; $display("FAIL waitreset_late: got %0d want 1", late_count); end
    endtask

    task automatic test_coincident();
        do_reset();
        in_valid = 1'b1;
        tick();
        tick();
        tick();
        vblank_pulse = 1'b1;
        tick();
        in_valid = 1'b0;
        vblank_pulse = 1'b0;
        checks++; if (state_out !== 2'd1) begin errors++; $display("FAIL coinc_state: got %0d want 1", state_out); end
        checks++; if (late_count !== 8'd1) begin errors++; $display("FAIL coinc_late: got %0d want 1", late_count); end
        tick();
        checks++; if (buffer_switch_event !== 1'b0 || state_out !== 2'd1) begin errors++; $display("FAIL coinc_no_swap: got sw=%0b st=%0d want 0 1", buffer_switch_event, state_out); end
        vblank_pulse = 1'b1;
        tick();
        vblank_pulse = 1'b0;
        checks++; if (buffer_switch_event !== 1'b1) begin errors++; $display("FAIL coinc_swap: got %0b want 1", buffer_switch_event); end
        tick();
        checks++; if (frame_count !== 16'd1 || late_count !== 8'd1) begin errors++; $display("FAIL coinc_counts: got fc=%0d lc=%0d want 1 1", frame_count, late_count); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        in_valid = 1'b0;
        vblank_pulse = 1'b0;
        in_data = '0;
        test_reset();
        test_fill();
        test_swap();
        test_late();
        test_toggle();
        test_reset_mid();
        test_coincident();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
